sdram_cmd: RTL and testbench



---
 rtl/sdram_cmd_pkg.sv | 65 ++++++
 rtl/sdram_cmd_wr_beat.sv | 49 ++++
 rtl/sdram_cmd.sv | 157 +++++++++++++++
 tb/tb_sdram_cmd.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_pkg.sv
// Shared state codes, JEDEC command encodings and mode-register layout for the
// SDRAM command/address pin driver.
package sdram_cmd_pkg;

  typedef enum logic [3:0] {
    I_NOP           = 4'd0,
    I_PRECHARGE     = 4'd1,
    I_TRP           = 4'd2,
    I_AUTO_REFRESH1 = 4'd3,
    I_TRF1          = 4'd4,
    I_AUTO_REFRESH2 = 4'd5,
    I_TRF2          = 4'd6,
    I_MRS           = 4'd7,
    I_TMRD          = 4'd8,
    I_DONE          = 4'd9
  } init_state_e;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TDAL   = 4'd8,
    W_AR     = 4'd9,
    W_TRFC   = 4'd10
  } work_state_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;

  // A10 doubles as all-bank precharge and auto-precharge on READ/WRITE.
  localparam int ADDR_AP_BIT = 10;
  localparam int MRS_WB_BIT  = 9;
  localparam int MRS_CL_LSB  = 4;
  localparam int MRS_BT_BIT  = 3;
  localparam int MRS_BL_LSB  = 0;

  function automatic logic [11:0] mrs_word(input int cas_lat, input int burst_len);
    logic [2:0] bl_code;
    case (burst_len)
      1:       bl_code = 3'd0;
      2:       bl_code = 3'd1;
      4:       bl_code = 3'd2;
      8:       bl_code = 3'd3;
      default: bl_code = 3'd2;
    endcase
    mrs_word                    = '0;
    mrs_word[MRS_WB_BIT]        = 1'b0;
    mrs_word[MRS_BT_BIT]        = 1'b0;
    mrs_word[MRS_CL_LSB +: 3]   = 3'(cas_lat);
    mrs_word[MRS_BL_LSB +: 3]   = bl_code;
  endfunction

endpackage

// File: rtl/sdram_cmd_wr_beat.sv
// Write-burst beat counter: drives DQ output enable and registered write data
// for exactly BURST_LEN cycles starting with the WRITE command cycle.
module sdram_wr_beat #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_dq_out,
  output logic              o_dq_oe,
  output logic              o_wr_beat
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_oe;
  logic [DATA_W-1:0] r_dq;

  // The start cycle issues the first beat, so the counter holds beats still owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_oe  <= 1'b0;
      r_dq  <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
      r_oe  <= 1'b0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(BURST_LEN - 1);
      r_oe  <= 1'b1;
      r_dq  <= i_wr_data;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      r_oe  <= 1'b1;
      r_dq  <= i_wr_data;
    end else begin
      r_oe  <= 1'b0;
    end
  end

  assign o_dq_out  = r_dq;
  assign o_dq_oe   = r_oe;
  assign o_wr_beat = r_oe;

endmodule

// File: rtl/sdram_cmd.sv
// Registers controller init/work states into JEDEC commands, bank/row/column
// addressing, CKE and write-data drive on the SDRAM pins.
module sdram_cmd
  import sdram_cmd_pkg::*;
#(
  parameter int ROW_W     = 13,
  parameter int COL_W     = 9,
  parameter int BA_W      = 2,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 3
) (
  input  logic                        clk_100m,
  input  logic                        rst,
  input  logic [3:0]                  init_state,
  input  logic [3:0]                  work_state,
  input  logic                        sys_rw_n,
  input  logic [BA_W+ROW_W+COL_W-1:0] sys_addr,
  input  logic [DATA_W-1:0]           sys_wr_data,
  output logic                        sdram_cke,
  output logic                        sdram_cs_n,
  output logic                        sdram_ras_n,
  output logic                        sdram_cas_n,
  output logic                        sdram_we_n,
  output logic [BA_W-1:0]             sdram_ba,
  output logic [ROW_W-1:0]            sdram_addr,
  output logic [DATA_W-1:0]           sdram_dq_out,
  output logic                        sdram_dq_oe,
  output logic                        wr_beat
);

  localparam int AW = BA_W + ROW_W + COL_W;

  logic             r_cke;
  logic [3:0]       r_cmd;
  logic [BA_W-1:0]  r_ba;
  logic [ROW_W-1:0] r_addr;
  logic [BA_W-1:0]  r_lat_ba;
  logic [COL_W-1:0] r_lat_col;
  logic [3:0]       r_init_prev;
  logic [3:0]       r_work_prev;

  logic             w_init_done;
  logic             w_init_edge;
  logic             w_work_edge;
  logic             w_wr_start;
  logic             w_abort;
  logic [3:0]       w_cmd;
  logic [BA_W-1:0]  w_ba;
  logic [ROW_W-1:0] w_addr;
  logic [ROW_W-1:0] w_col_addr;
  logic [BA_W-1:0]  w_lat_ba;
  logic [COL_W-1:0] w_lat_col;
  logic             w_unused_rw;

  // Direction is already implied by work_state; sys_rw_n is not needed here.
  assign w_unused_rw = sys_rw_n;

  assign w_init_done = (init_state == I_DONE);
  assign w_init_edge = (init_state != r_init_prev);
  assign w_work_edge = (work_state != r_work_prev);
  assign w_wr_start  = w_init_done && w_work_edge && (work_state == W_WRITE);
  assign w_abort     = w_init_done && w_work_edge && (work_state == W_ACTIVE);

  always_comb begin
    w_cmd     = CMD_NOP;
    w_ba      = r_ba;
    w_addr    = r_addr;
    w_lat_ba  = r_lat_ba;
    w_lat_col = r_lat_col;
    w_col_addr                   = '0;
    w_col_addr[COL_W-1:0]        = r_lat_col;
    w_col_addr[ADDR_AP_BIT]      = 1'b1;
    if (!w_init_done) begin
      if (w_init_edge) begin
        case (init_state)
          I_PRECHARGE: begin
            w_cmd               = CMD_PRECHARGE;
            w_addr              = '0;
            w_addr[ADDR_AP_BIT] = 1'b1;
          end
          I_AUTO_REFRESH1, I_AUTO_REFRESH2: w_cmd = CMD_REFRESH;
          I_MRS: begin
            w_cmd  = CMD_MRS;
            w_ba   = '0;
            w_addr = ROW_W'(mrs_word(CAS_LAT, BURST_LEN));
          end
          default: w_cmd = CMD_NOP;
        endcase
      end
    end else if (w_work_edge) begin
      case (work_state)
        W_ACTIVE: begin
          w_cmd     = CMD_ACTIVE;
          w_ba      = sys_addr[AW-1 -: BA_W];
          w_addr    = sys_addr[COL_W +: ROW_W];
          w_lat_ba  = sys_addr[AW-1 -: BA_W];
          w_lat_col = sys_addr[COL_W-1:0];
        end
        W_READ: begin
          w_cmd  = CMD_READ;
          w_ba   = r_lat_ba;
          w_addr = w_col_addr;
        end
        W_WRITE: begin
          w_cmd  = CMD_WRITE;
          w_ba   = r_lat_ba;
          w_addr = w_col_addr;
        end
        W_AR:    w_cmd = CMD_REFRESH;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_cke       <= 1'b0;
      r_cmd       <= CMD_INHIBIT;
      r_ba        <= '0;
      r_addr      <= '0;
      r_lat_ba    <= '0;
      r_lat_col   <= '0;
      r_init_prev <= '0;
      r_work_prev <= '0;
    end else begin
      r_cke       <= 1'b1;
      r_cmd       <= w_cmd;
      r_ba        <= w_ba;
      r_addr      <= w_addr;
      r_lat_ba    <= w_lat_ba;
      r_lat_col   <= w_lat_col;
      r_init_prev <= init_state;
      r_work_prev <= work_state;
    end
  end

  sdram_wr_beat #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) u_wr_beat (
    .clk       (clk_100m),
    .rst       (rst),
    .i_start   (w_wr_start),
    .i_abort   (w_abort),
    .i_wr_data (sys_wr_data),
    .o_dq_out  (sdram_dq_out),
    .o_dq_oe   (sdram_dq_oe),
    .o_wr_beat (wr_beat)
  );

  assign sdram_cke = r_cke;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
  assign sdram_ba   = r_ba;
  assign sdram_addr = r_addr;

endmodule

// File: tb/tb_sdram_cmd.sv
// Self-checking bench for sdram_cmd: directed vector table, reset corner cases
// and a randomized run scored against a look-back reference model.
module tb_sdram_cmd;

  localparam int BL = 4;
  localparam int NR = 400;

  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001,
                         MRS = 4'b0000, ACT = 4'b0011, RD  = 4'b0101,
                         WR  = 4'b0100, INH = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  init_st = '0;
  logic [3:0]  work_st = '0;
  logic        rw_n = 1'b0;
  logic [23:0] sa = '0;
  logic [15:0] wd = '0;
  logic        cke, cs_n, ras_n, cas_n, we_n, dq_oe, wrb;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [15:0] dq;
  logic [3:0]  cmd;

  assign cmd = {cs_n, ras_n, cas_n, we_n};

  sdram_cmd dut (
    .clk_100m     (clk),
    .rst          (rst),
    .init_state   (init_st),
    .work_state   (work_st),
    .sys_rw_n     (rw_n),
    .sys_addr     (sa),
    .sys_wr_data  (wd),
    .sdram_cke    (cke),
    .sdram_cs_n   (cs_n),
    .sdram_ras_n  (ras_n),
    .sdram_cas_n  (cas_n),
    .sdram_we_n   (we_n),
    .sdram_ba     (ba),
    .sdram_addr   (addr),
    .sdram_dq_out (dq),
    .sdram_dq_oe  (dq_oe),
    .wr_beat      (wrb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [3:0]  ini;
    logic [3:0]  wrk;
    logic [23:0] sa;
    logic [15:0] wd;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        oe;
    logic [15:0] dq;
  } vec_t;

  vec_t tbl[64];
  int   ntbl = 0;

  task automatic add(input logic [3:0] i, input logic [3:0] w, input logic [23:0] a,
                     input logic [15:0] d, input logic [3:0] c, input logic [1:0] b,
                     input logic [12:0] ad, input logic o, input logic [15:0] q);
    tbl[ntbl].ini = i;  tbl[ntbl].wrk = w;  tbl[ntbl].sa = a;   tbl[ntbl].wd = d;
    tbl[ntbl].cmd = c;  tbl[ntbl].ba = b;   tbl[ntbl].addr = ad;
    tbl[ntbl].oe = o;   tbl[ntbl].dq = q;
    ntbl++;
  endtask

  // Called at a negedge: apply inputs, let one active edge pass, sample 1 ns later.
  task automatic step(input logic [3:0] i, input logic [3:0] w, input logic [23:0] a,
                      input logic [15:0] d);
    init_st = i; work_st = w; sa = a; wd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int n);
    string t;
    step(tbl[n].ini, tbl[n].wrk, tbl[n].sa, tbl[n].wd);
    t = $sformatf("vec%0d", n);
    chk({t, ".cke"},  32'(cke),   32'd1);
    chk({t, ".cmd"},  32'(cmd),   32'(tbl[n].cmd));
    chk({t, ".ba"},   32'(ba),    32'(tbl[n].ba));
    chk({t, ".addr"}, 32'(addr),  32'(tbl[n].addr));
    chk({t, ".oe"},   32'(dq_oe), 32'(tbl[n].oe));
    chk({t, ".wrb"},  32'(wrb),   32'(tbl[n].oe));
    if (tbl[n].oe) chk({t, ".dq"}, 32'(dq), 32'(tbl[n].dq));
    @(negedge clk);
  endtask

  // Reference model history; index 0 is the post-reset state.
  logic [3:0]  m_ini[0:NR];
  logic [3:0]  m_wrk[0:NR];
  logic [23:0] m_sa[0:NR];
  logic [15:0] m_wd[0:NR];

  function automatic logic work_edge_at(input int j);
    return (m_ini[j] == 4'd9) && (m_wrk[j] != m_wrk[j-1]);
  endfunction

  // Output enable at cycle k: the most recent write/activate edge within the last BL cycles decides.
  function automatic logic model_oe(input int k);
    for (int j = k; j >= 1 && j > k - BL; j--) begin
      if (work_edge_at(j) && m_wrk[j] == 4'd1) return 1'b0;
      if (work_edge_at(j) && m_wrk[j] == 4'd6) return 1'b1;
    end
    return 1'b0;
  endfunction

  localparam logic [23:0] SA_R = {2'd2, 13'h1A5, 9'h007};
  localparam logic [23:0] SA_W = {2'd1, 13'h0F0, 9'h1C3};
  localparam logic [23:0] G    = 24'hC5A5A5;

  initial begin
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [12:0] e_addr;
    logic [1:0]  l_ba;
    logic [8:0]  l_col;
    logic        e_oe;
    logic [3:0]  ni, nw;
    string       t;

    // Init, read, write, held-state, guard and abort vectors.
    add(0, 0, G, 0, NOP, 0, 13'h000, 0, 0);
    add(1, 0, G, 0, PRE, 0, 13'h400, 0, 0);
    add(2, 0, G, 0, NOP, 0, 13'h400, 0, 0);
    add(3, 0, G, 0, REF, 0, 13'h400, 0, 0);
    add(4, 0, G, 0, NOP, 0, 13'h400, 0, 0);
    add(5, 0, G, 0, REF, 0, 13'h400, 0, 0);
    add(6, 0, G, 0, NOP, 0, 13'h400, 0, 0);
    add(7, 0, G, 0, MRS, 0, 13'h032, 0, 0);
    add(8, 0, G, 0, NOP, 0, 13'h032, 0, 0);
    add(9, 0, G, 0, NOP, 0, 13'h032, 0, 0);
    add(9, 1, SA_R, 0, ACT, 2, 13'h1A5, 0, 0);
    add(9, 2, G, 0, NOP, 2, 13'h1A5, 0, 0);
    add(9, 2, G, 0, NOP, 2, 13'h1A5, 0, 0);
    add(9, 3, G, 0, RD,  2, 13'h407, 0, 0);
    add(9, 4, G, 0, NOP, 2, 13'h407, 0, 0);
    add(9, 4, G, 0, NOP, 2, 13'h407, 0, 0);
    add(9, 5, G, 0, NOP, 2, 13'h407, 0, 0);
    add(9, 0, G, 0, NOP, 2, 13'h407, 0, 0);
    add(9, 1, SA_W, 0, ACT, 1, 13'h0F0, 0, 0);
    add(9, 2, G, 0,     NOP, 1, 13'h0F0, 0, 0);
    add(9, 6, G, 16'hA1, WR, 1, 13'h5C3, 1, 16'hA1);
    add(9, 7, G, 16'hA2, NOP, 1, 13'h5C3, 1, 16'hA2);
    add(9, 7, G, 16'hA3, NOP, 1, 13'h5C3, 1, 16'hA3);
    add(9, 7, G, 16'hA4, NOP, 1, 13'h5C3, 1, 16'hA4);
    add(9, 7, G, 16'h55, NOP, 1, 13'h5C3, 0, 0);
    add(9, 8, G, 16'h66, NOP, 1, 13'h5C3, 0, 0);
    add(9, 0, G, 0, NOP, 1, 13'h5C3, 0, 0);
    add(9, 9, G, 0, REF, 1, 13'h5C3, 0, 0);
    add(9, 9, G, 0, NOP, 1, 13'h5C3, 0, 0);
    add(9, 9, G, 0, NOP, 1, 13'h5C3, 0, 0);
    add(2, 1, SA_R, 0, NOP, 1, 13'h5C3, 0, 0);
    add(2, 1, SA_R, 0, NOP, 1, 13'h5C3, 0, 0);
    add(9, 1, SA_R, 0, NOP, 1, 13'h5C3, 0, 0);
    add(9, 0, G, 0, NOP, 1, 13'h5C3, 0, 0);
    add(9, 6, G, 16'hB1, WR, 1, 13'h5C3, 1, 16'hB1);
    add(9, 7, G, 16'hB2, NOP, 1, 13'h5C3, 1, 16'hB2);
    add(9, 1, SA_R, 16'hB3, ACT, 2, 13'h1A5, 0, 0);
    add(9, 2, G, 16'hB4, NOP, 2, 13'h1A5, 0, 0);
    add(9, 6, G, 16'hC1, WR, 2, 13'h407, 1, 16'hC1);
    add(9, 7, G, 16'hC2, NOP, 2, 13'h407, 1, 16'hC2);

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d.cke", i), 32'(cke), 32'd0);
      chk($sformatf("rst%0d.cmd", i), 32'(cmd), 32'(INH));
      chk($sformatf("rst%0d.oe", i),  32'(dq_oe), 32'd0);
      chk($sformatf("rst%0d.addr", i), 32'(addr), 32'd0);
    end
    rst = 1'b0;
    for (int n = 0; n < ntbl; n++) run_vec(n);

    // Asynchronous reset on burst beat 2, sampled well before the next edge.
    rst = 1'b1;
    #1;
    chk("async_rst.oe",  32'(dq_oe), 32'd0);
    chk("async_rst.cmd", 32'(cmd),   32'(INH));
    chk("async_rst.cke", 32'(cke),   32'd0);
    chk("async_rst.wrb", 32'(wrb),   32'd0);
    chk("async_rst.dq",  32'(dq),    32'd0);
    chk("async_rst.ba",  32'(ba),    32'd0);
    @(negedge clk);
    @(negedge clk);

    // Randomized run against the reference model, starting from reset.
    m_ini[0] = 0; m_wrk[0] = 0; m_sa[0] = 0; m_wd[0] = 0;
    e_ba = 0; e_addr = 0; l_ba = 0; l_col = 0;
    rst = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      if (k <= 40) ni = 4'($urandom_range(0, 15));
      else ni = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd9;
      case ($urandom_range(0, 3))
        0, 1:    nw = m_wrk[k-1];
        2:       nw = 4'($urandom_range(0, 15));
        default: nw = ($urandom_range(0, 1) == 1) ? 4'd6 : 4'd1;
      endcase
      m_ini[k] = ni; m_wrk[k] = nw; m_sa[k] = 24'($urandom); m_wd[k] = 16'($urandom);

      e_cmd = NOP;
      if (m_ini[k] != 4'd9) begin
        if (m_ini[k] != m_ini[k-1]) begin
          case (m_ini[k])
            4'd1:       begin e_cmd = PRE; e_addr = 13'h400; end
            4'd3, 4'd5: e_cmd = REF;
            4'd7:       begin e_cmd = MRS; e_ba = 0; e_addr = 13'h032; end
            default:    e_cmd = NOP;
          endcase
        end
      end else if (work_edge_at(k)) begin
        case (m_wrk[k])
          4'd1: begin
            e_cmd = ACT; e_ba = m_sa[k][23:22]; e_addr = m_sa[k][21:9];
            l_ba = m_sa[k][23:22]; l_col = m_sa[k][8:0];
          end
          4'd3, 4'd6: begin
            e_cmd = (m_wrk[k] == 4'd3) ? RD : WR;
            e_ba = l_ba; e_addr = 13'h400 + {4'd0, l_col};
          end
          4'd9:    e_cmd = REF;
          default: e_cmd = NOP;
        endcase
      end
      e_oe = model_oe(k);

      step(m_ini[k], m_wrk[k], m_sa[k], m_wd[k]);
      t = $sformatf("rnd%0d", k);
      chk({t, ".cke"},  32'(cke),   32'd1);
      chk({t, ".cmd"},  32'(cmd),   32'(e_cmd));
      chk({t, ".ba"},   32'(ba),    32'(e_ba));
      chk({t, ".addr"}, 32'(addr),  32'(e_addr));
      chk({t, ".oe"},   32'(dq_oe), 32'(e_oe));
      chk({t, ".wrb"},  32'(wrb),   32'(e_oe));
      if (e_oe) chk({t, ".dq"}, 32'(dq), 32'(m_wd[k]));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
